// File: rtl/ima_adpcm_pkg.sv
// Shared types, constants and lookup helpers for the IMA ADPCM codec blocks.
package ima_adpcm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSign,
        StBit2,
        StBit1,
        StBit0,
        StDone
    } state_e;

    localparam int unsigned STEP_MAX_IDX = 88;

    localparam int STEP_TAB [89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    // Indices past the end of the table saturate to the largest step.
    function automatic logic [14:0] step_lookup(input logic [6:0] idx);
        step_lookup = (idx > 7'(STEP_MAX_IDX)) ? 15'd32767 : 15'(STEP_TAB[idx]);
    endfunction

    // Step-index adjustment from the 3-bit magnitude code.
    function automatic logic signed [7:0] idx_delta(input logic [2:0] mag);
        case (mag)
            3'd4:    idx_delta = 8'sd2;
            3'd5:    idx_delta = 8'sd4;
            3'd6:    idx_delta = 8'sd6;
            3'd7:    idx_delta = 8'sd8;
            default: idx_delta = -8'sd1;
        endcase
    endfunction

endpackage

// File: rtl/ima_adpcm_step_rom.sv
// Registered step-size lookup; one cycle from index to step.
module ima_adpcm_step_rom
    import ima_adpcm_pkg::*;
(
    input  logic        clock,
    input  logic [6:0]  index,
    output logic [14:0] step
);

    // Register the table output every cycle.
    always_ff @(posedge clock) begin
        step <= step_lookup(index);
    end

endmodule

// File: rtl/ima_adpcm_enc_mc.sv
// Multi-channel IMA ADPCM encoder: one bit-serial quantiser shared by NUM_CH channels.
module ima_adpcm_enc_mc
    import ima_adpcm_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [15:0]     inSamp,
    input  logic [CH_W-1:0] inChan,
    input  logic            inValid,
    output logic            inReady,
    input  logic            ldValid,
    input  logic [CH_W-1:0] ldChan,
    input  logic [15:0]     ldPredict,
    input  logic [6:0]      ldStepIndex,
    output logic [3:0]      outPCM,
    output logic [CH_W-1:0] outChan,
    output logic            outValid,
    output logic [15:0]     outPredictSamp,
    output logic [6:0]      outStepIndex
);

    state_e             state_q, state_d;
    logic [15:0]        samp_q;
    logic [CH_W-1:0]    chan_q;
    logic signed [18:0] pred_q;
    logic [6:0]         idx_q;
    logic [19:0]        diff_q, diff_d;
    logic               sign_q, sign_d;
    logic [2:0]         code_q, code_d;
    logic [18:0]        dequant_q, dequant_d;

    logic signed [18:0] pred_mem [NUM_CH];
    logic [6:0]         idx_mem [NUM_CH];

    logic [6:0]         rom_index;
    logic [14:0]        step;

    logic               ld_take, samp_take, ld_chan_ok, in_chan_ok;
    logic signed [19:0] pre;
    logic signed [18:0] pred_new;
    logic signed [7:0]  idx_sum;
    logic [6:0]         idx_new;
    logic [15:0]        pred_round;

    // Reset gates ready combinationally so no request is taken while it is held.
    assign inReady    = (state_q == StIdle) && !reset;
    assign ld_take    = inReady && ldValid;
    assign samp_take  = inReady && inValid && !ldValid;
    assign ld_chan_ok = 32'(ldChan) < NUM_CH;
    assign in_chan_ok = 32'(inChan) < NUM_CH;

    // The ROM sees the channel's stored index during FETCH, then the latched copy.
    assign rom_index = (state_q == StFetch) ? idx_mem[chan_q] : idx_q;

    ima_adpcm_step_rom u_step_rom (
        .clock(clock),
        .index(rom_index),
        .step (step)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next state: one step per cycle; out-of-range channels are dropped in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (samp_take && in_chan_ok) state_d = StFetch;
            StFetch: state_d = StSign;
            StSign:  state_d = StBit2;
            StBit2:  state_d = StBit1;
            StBit1:  state_d = StBit0;
            StBit0:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Quantiser: difference, sign fold, then successive approximation of three bits.
    always_comb begin
        diff_d    = diff_q;
        sign_d    = sign_q;
        code_d    = code_q;
        dequant_d = dequant_q;
        unique case (state_q)
            StFetch: begin
                diff_d = {samp_q[15], samp_q, 3'b000} - {pred_mem[chan_q][18], pred_mem[chan_q]};
                sign_d = 1'b0;
                code_d = 3'b000;
            end
            StSign: begin
                if (diff_q[19]) begin
                    sign_d = 1'b1;
                    diff_d = -diff_q;
                end
                dequant_d = {4'b0000, step};
            end
            StBit2: begin
                if (diff_q[19:3] >= {2'b00, step}) begin
                    code_d[2]    = 1'b1;
                    diff_d[19:3] = diff_q[19:3] - {2'b00, step};
                    dequant_d    = dequant_q + {1'b0, step, 3'b000};
                end
            end
            StBit1: begin
                if (diff_q[19:2] >= {3'b000, step}) begin
                    code_d[1]    = 1'b1;
                    diff_d[19:2] = diff_q[19:2] - {3'b000, step};
                    dequant_d    = dequant_q + {2'b00, step, 2'b00};
                end
            end
            StBit0: begin
                if (diff_q[19:1] >= {4'b0000, step}) begin
                    code_d[0]    = 1'b1;
                    diff_d[19:1] = diff_q[19:1] - {4'b0000, step};
                    dequant_d    = dequant_q + {3'b000, step, 1'b0};
                end
            end
            default: ;
        endcase
    end

    // Predictor/index update and the rounded, saturated sample view.
    always_comb begin
        if (sign_q) pre = {pred_q[18], pred_q} - {1'b0, dequant_q};
        else        pre = {pred_q[18], pred_q} + {1'b0, dequant_q};
        if (pre[19] != pre[18]) pred_new = pre[19] ? 19'h40000 : 19'h3FFFF;
        else                    pred_new = pre[18:0];
        idx_sum = $signed({1'b0, idx_q}) + idx_delta(code_q);
        if (idx_sum < 8'sd0)       idx_new = 7'd0;
        else if (idx_sum > 8'sd88) idx_new = 7'(STEP_MAX_IDX);
        else                       idx_new = idx_sum[6:0];
        if (pred_new[18:3] == 16'h7FFF && pred_new[2]) pred_round = 16'h7FFF;
        else pred_round = pred_new[18:3] + {15'd0, pred_new[2]};
    end

    // Datapath registers, per-channel state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            samp_q         <= '0;
            chan_q         <= '0;
            pred_q         <= '0;
            idx_q          <= '0;
            diff_q         <= '0;
            sign_q         <= 1'b0;
            code_q         <= '0;
            dequant_q      <= '0;
            outPCM         <= '0;
            outChan        <= '0;
            outValid       <= 1'b0;
            outPredictSamp <= '0;
            outStepIndex   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pred_mem[i] <= '0;
                idx_mem[i]  <= '0;
            end
        end else begin
            diff_q    <= diff_d;
            sign_q    <= sign_d;
            code_q    <= code_d;
            dequant_q <= dequant_d;
            outValid  <= 1'b0;
            if (samp_take) begin
                samp_q <= inSamp;
                chan_q <= inChan;
            end
            if (ld_take && ld_chan_ok) begin
                pred_mem[ldChan] <= {ldPredict, 3'b000};
                idx_mem[ldChan]  <= (ldStepIndex > 7'(STEP_MAX_IDX)) ?
                                    7'(STEP_MAX_IDX) : ldStepIndex;
            end
            if (state_q == StFetch) begin
                pred_q <= pred_mem[chan_q];
                idx_q  <= idx_mem[chan_q];
            end
            if (state_q == StDone) begin
                pred_mem[chan_q] <= pred_new;
                idx_mem[chan_q]  <= idx_new;
                outPCM           <= {sign_q, code_q};
                outChan          <= chan_q;
                outValid         <= 1'b1;
                outPredictSamp   <= pred_round;
                outStepIndex     <= idx_new;
            end
        end
    end

endmodule

// File: tb/tb_ima_adpcm_enc_mc.sv
// Bench for the multi-channel IMA ADPCM encoder: vector table, corner sequences, random vs model.
module tb_ima_adpcm_enc_mc;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] inSamp;
    logic        inChan;
    logic        inValid;
    logic        inReady;
    logic        ldValid;
    logic        ldChan;
    logic [15:0] ldPredict;
    logic [6:0]  ldStepIndex;
    logic [3:0]  outPCM;
    logic        outChan;
    logic        outValid;
    logic [15:0] outPredictSamp;
    logic [6:0]  outStepIndex;

    ima_adpcm_enc_mc #(.NUM_CH(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .inSamp        (inSamp),
        .inChan        (inChan),
        .inValid       (inValid),
        .inReady       (inReady),
        .ldValid       (ldValid),
        .ldChan        (ldChan),
        .ldPredict     (ldPredict),
        .ldStepIndex   (ldStepIndex),
        .outPCM        (outPCM),
        .outChan       (outChan),
        .outValid      (outValid),
        .outPredictSamp(outPredictSamp),
        .outStepIndex  (outStepIndex)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    localparam int TB_STEP [89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    typedef struct packed {
        logic [3:0]  pcm;
        logic [15:0] ps;
        logic [6:0]  si;
        logic        ch;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        load;
        logic [15:0] ld_p;
        logic [6:0]  ld_i;
        int          ch;
        logic [15:0] samp;
        logic [3:0]  pcm;
        logic [15:0] ps;
        logic [6:0]  si;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference channel state: predictor in eighths of an LSB, step index.
    int m_pred [2];
    int m_idx  [2];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pred[c] = 0;
            m_idx[c]  = 0;
        end
    endtask

    task automatic model_load(input int ch, input logic [15:0] p, input logic [6:0] ix);
        int sp;
        sp = $signed(p);
        m_pred[ch] = sp * 8;
        m_idx[ch]  = (int'(ix) > 88) ? 88 : int'(ix);
    endtask

    // IMA quantiser in plain integer arithmetic, all values scaled by 8.
    task automatic model_encode(input int ch, input logic [15:0] s,
                                output int pcm, output int ps, output int si);
        int sv, step, diff, neg, mag, dq, code, p;
        sv   = $signed(s);
        step = TB_STEP[m_idx[ch]];
        diff = sv * 8 - m_pred[ch];
        neg  = (diff < 0) ? 1 : 0;
        mag  = neg ? -diff : diff;
        dq   = step;
        code = 0;
        for (int b = 2; b >= 0; b--) begin
            if (mag >= (step << (b + 1))) begin
                code = code | (1 << b);
                mag  = mag - (step << (b + 1));
                dq   = dq + (step << (b + 1));
            end
        end
        p = neg ? m_pred[ch] - dq : m_pred[ch] + dq;
        if (p > 262143)  p = 262143;
        if (p < -262144) p = -262144;
        m_pred[ch] = p;
        si = m_idx[ch] + ((code < 4) ? -1 : (code - 3) * 2);
        if (si < 0)  si = 0;
        if (si > 88) si = 88;
        m_idx[ch] = si;
        ps = (p >>> 3) + ((p >> 2) & 1);
        if (ps > 32767) ps = 32767;
        pcm = neg * 8 + code;
    endtask

    // Tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic do_load(input int ch, input logic [15:0] p, input logic [6:0] ix);
        ldValid = 1'b1;
        ldChan = 1'(ch);
        ldPredict = p;
        ldStepIndex = ix;
        @(posedge clock);
        #1 ldValid = 1'b0;
        model_load(ch, p, ix);
    endtask

    // Waits for the output strobe, counting falling edges since the accepting edge.
    task automatic wait_out(output int lat, output obs_t o);
        lat = -1;
        o = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (outValid) begin
                lat = k;
                o.pcm = outPCM;
                o.ps = outPredictSamp;
                o.si = outStepIndex;
                o.ch = outChan;
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_sample(input int ch, input logic [15:0] s,
                                output int lat, output obs_t o);
        int w;
        inSamp = s;
        inChan = 1'(ch);
        inValid = 1'b1;
        w = 0;
        @(negedge clock);
        while (!inReady && w < 20) begin
            w++;
            @(negedge clock);
        end
        if (!inReady) begin
            check("inReady timeout", 0, 1);
            inValid = 1'b0;
            lat = -1;
            o = '0;
            return;
        end
        @(posedge clock);
        #1 inValid = 1'b0;
        wait_out(lat, o);
    endtask

    initial begin
        vec_t vec [7];
        obs_t o;
        int   lat, seen;
        int   e_pcm, e_ps, e_si;
        int   ch;
        logic [15:0] s;

        //            rst   load  ld_p      ld_i   ch samp      pcm   ps        si
        vec[0] = '{1'b1, 1'b0, 16'h0000, 7'd0,  0, 16'h0000, 4'h0, 16'h0001, 7'd0};
        vec[1] = '{1'b1, 1'b0, 16'h0000, 7'd0,  0, 16'h1000, 4'h7, 16'h000D, 7'd8};
        vec[2] = '{1'b0, 1'b0, 16'h0000, 7'd0,  1, 16'h0000, 4'h0, 16'h0001, 7'd0};
        vec[3] = '{1'b0, 1'b0, 16'h0000, 7'd0,  0, 16'h1000, 4'h7, 16'h002B, 7'd16};
        vec[4] = '{1'b1, 1'b0, 16'h0000, 7'd0,  0, 16'hF000, 4'hF, 16'hFFF3, 7'd8};
        vec[5] = '{1'b0, 1'b0, 16'h0000, 7'd0,  1, 16'hF000, 4'hF, 16'hFFF3, 7'd8};
        vec[6] = '{1'b0, 1'b1, 16'h8001, 7'd88, 1, 16'h8000, 4'h8, 16'h8000, 7'd87};

        reset = 1'b1;
        inSamp = '0;
        inChan = 1'b0;
        inValid = 1'b0;
        ldValid = 1'b0;
        ldChan = 1'b0;
        ldPredict = '0;
        ldStepIndex = '0;

        // Reset state.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset inReady", inReady, 0);
        check("reset outValid", outValid, 0);
        check("reset outPredictSamp", outPredictSamp, 0);
        check("reset outStepIndex", outStepIndex, 0);
        check("reset outPCM", outPCM, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("post-reset inReady", inReady, 1);
        @(posedge clock);
        #1;
        model_reset();

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            if (vec[i].rst) do_reset();
            if (vec[i].load) do_load(vec[i].ch, vec[i].ld_p, vec[i].ld_i);
            apply_sample(vec[i].ch, vec[i].samp, lat, o);
            check($sformatf("vec%0d latency", i), lat, 7);
            check($sformatf("vec%0d outPCM", i), o.pcm, vec[i].pcm);
            check($sformatf("vec%0d outChan", i), o.ch, vec[i].ch);
            check($sformatf("vec%0d outPredictSamp", i), o.ps, vec[i].ps);
            check($sformatf("vec%0d outStepIndex", i), o.si, vec[i].si);
        end

        // Load with clamped index, then positive saturation.
        do_load(1, 16'h7FFF, 7'd100);
        @(negedge clock);
        check("load inReady", inReady, 1);
        check("load outValid", outValid, 0);
        @(posedge clock);
        #1;
        apply_sample(1, 16'h7FFF, lat, o);
        check("sat latency", lat, 7);
        check("sat outPCM", o.pcm, 4'h0);
        check("sat outPredictSamp", o.ps, 16'h7FFF);
        check("sat outStepIndex", o.si, 87);

        // Load and sample together: load first, sample next cycle with loaded state.
        ldValid = 1'b1;
        ldChan = 1'b0;
        ldPredict = 16'h1000;
        ldStepIndex = 7'd10;
        inValid = 1'b1;
        inChan = 1'b0;
        inSamp = 16'h1000;
        @(negedge clock);
        check("both inReady", inReady, 1);
        @(posedge clock);
        #1 ldValid = 1'b0;
        @(negedge clock);
        check("both inReady after load", inReady, 1);
        check("both outValid after load", outValid, 0);
        @(posedge clock);
        #1 inValid = 1'b0;
        wait_out(lat, o);
        check("both latency", lat, 7);
        check("both outPCM", o.pcm, 4'h0);
        check("both outPredictSamp", o.ps, 16'h1002);
        check("both outStepIndex", o.si, 9);
        @(negedge clock);
        check("outValid single cycle", outValid, 0);
        check("outPredictSamp held", outPredictSamp, 16'h1002);
        @(posedge clock);
        #1;

        // Reset during BIT1 aborts the encode.
        inSamp = 16'h1000;
        inChan = 1'b0;
        inValid = 1'b1;
        @(negedge clock);
        check("abort inReady", inReady, 1);
        @(posedge clock);
        #1 inValid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("abort inReady in reset", inReady, 0);
        @(posedge clock);
        @(negedge clock);
        check("abort reset inReady", inReady, 0);
        check("abort reset outPredictSamp", outPredictSamp, 0);
        check("abort reset outStepIndex", outStepIndex, 0);
        check("abort reset outValid", outValid, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        seen = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 1) check("abort inReady after reset", inReady, 1);
            if (outValid) seen = 1;
        end
        check("abort no outValid", seen, 0);
        @(posedge clock);
        #1;
        apply_sample(0, 16'h0000, lat, o);
        check("abort next latency", lat, 7);
        check("abort next outPredictSamp", o.ps, 16'h0001);
        check("abort next outStepIndex", o.si, 0);

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            ch = $urandom_range(0, 1);
            if ($urandom_range(0, 9) < 2) begin
                case ($urandom_range(0, 3))
                    0:       s = 16'h7FFF;
                    1:       s = 16'h8001;
                    default: s = 16'($urandom);
                endcase
                do_load(ch, s, 7'($urandom_range(0, 127)));
            end
            case ($urandom_range(0, 4))
                0:       s = 16'h7FFF;
                1:       s = 16'h8000;
                default: s = 16'($urandom);
            endcase
            model_encode(ch, s, e_pcm, e_ps, e_si);
            apply_sample(ch, s, lat, o);
            check($sformatf("rnd%0d latency", n), lat, 7);
            check($sformatf("rnd%0d outPCM", n), o.pcm, e_pcm);
            check($sformatf("rnd%0d outChan", n), o.ch, ch);
            check($sformatf("rnd%0d outPredictSamp", n), o.ps, e_ps & 32'hFFFF);
            check($sformatf("rnd%0d outStepIndex", n), o.si, e_si);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ima_adpcm_enc_mc.md
Name: ima_adpcm_enc_mc

Overview:
Multi-channel IMA ADPCM encoder, the successor to the single-channel encoder. It time-multiplexes one bit-serial quantiser datapath across NUM_CH independent channels, each with its own predictor and step index. It adds a state-load port, so block headers can resynchronise any channel, and it saturates the rounded predictor output. It sits between the PCM sample mux and the ADPCM nibble packer.

Parameters:
NUM_CH, 2, number of independent channels (1..16).
CH_W, $clog2(NUM_CH) (minimum 1), channel-number width; derived, not overridden.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
inSamp  in  16  signed input PCM sample
inChan  in  CH_W  channel of inSamp
inValid  in  1  sample request
inReady  out  1  high only in IDLE; a request (sample or load) is accepted when its valid and inReady are both high
ldValid  in  1  channel state-load request
ldChan  in  CH_W  channel to load
ldPredict  in  16  signed predictor to load
ldStepIndex  in  7  step index to load
outPCM  out  4  encoded nibble {sign, b2, b1, b0}
outChan  out  CH_W  channel of outPCM
outValid  out  1  one-cycle strobe
outPredictSamp  out  16  updated predictor of outChan, rounded and saturated
outStepIndex  out  7  updated step index of outChan

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0, including inReady.
  - FSM goes to IDLE.
  - Every channel: predictor = 0, index = 0.
  - Asserting reset mid-encode aborts the encode; no outValid follows.
- Per-channel state: predictor is 19-bit signed (16.3 fixed point); index is 7-bit, range 0..88.
- Step-size ROM: 89 standard IMA entries, 7..32767; any index > 88 returns 32767. The ROM is registered, one cycle of latency.
- FSM, one state per cycle:
  - IDLE:
    - inReady = 1.
    - ldValid has priority over inValid when both are high.
    - Load: channel predictor = {ldPredict, 3'b0}; index = min(ldStepIndex, 88). Stay in IDLE with inReady = 1; no output.
    - Sample: latch inSamp and inChan, deassert inReady, go to FETCH.
  - FETCH:
    - Read the channel's predictor and index; present the index to the ROM.
    - diff(20b) = sext(inSamp)<<3 − sext(predictor).
  - SIGN:
    - If diff < 0: sign = 1 and diff = −diff.
    - dequant = stepSize (zero-extended to 19 bits).
  - BIT2: if diff[19:3] ≥ stepSize then b2 = 1, diff[19:3] −= stepSize, dequant += stepSize<<3.
  - BIT1: same test on diff[19:2]; if set, dequant += stepSize<<2.
  - BIT0: same test on diff[19:1]; if set, dequant += stepSize<<1.
  - DONE:
    - pre = sext(predictor) ± dequant (20 bits), subtracting when sign = 1.
    - New predictor = pre clamped to [−2^18, 2^18−1].
    - New index = index + delta, clamped to 0..88. delta is −1 for {b2,b1,b0} = 0..3, and +2/+4/+6/+8 for 4..7.
    - Write both back to the channel, register the outputs, go to IDLE.
- Outputs:
  - outValid is high exactly one cycle, in the cycle after DONE: 7 clocks after the accepting edge.
  - Throughput is one sample per 7 cycles.
  - outPCM, outChan, outPredictSamp and outStepIndex hold until the next outValid.
  - outPredictSamp = pred[18:3] + pred[2], saturated to 0x7FFF when the addition overflows.
- inChan ≥ NUM_CH, or ldChan ≥ NUM_CH: the request is accepted and discarded. No state change, no output.
- Channels never interact; back-to-back samples on alternating channels use fully independent state.

Decomposition:
- Package ima_adpcm_pkg holds:
  - state encodings IDLE..DONE;
  - STEP_MAX_IDX = 88;
  - the 89-entry step table as a function;
  - the index-delta function.
- One sub-module, ima_adpcm_step_rom: a registered lookup from index (7b) to stepSize (15b). It is shared with the future decoder.

Test Plan:
- Reset, then ch0 inSamp = 0x0000 -> outChan 0, outPCM 0x0, outPredictSamp 0x0001, outStepIndex 0; outValid exactly 7 clocks after acceptance.
- Reset, then ch0 0x1000 -> outPCM 0x7, outPredictSamp 0x000D, outStepIndex 8. Then ch1 0x0000 -> outPCM 0x0, outPredictSamp 0x0001, outStepIndex 0 (ch1 unaffected by ch0). Then ch0 0x1000 -> outPCM 0x7, outStepIndex 16.
- Reset, then ch0 0xF000 -> outPCM 0xF, outPredictSamp 0xFFF3, outStepIndex 8.
- Load ch1 with predict 0x7FFF, index 100 (clamped to 88), then ch1 sample 0x7FFF -> outPCM 0x0, outPredictSamp 0x7FFF (saturated), outStepIndex 87.
- ldValid and inValid high together in IDLE -> load taken first, inReady stays 1; the sample is accepted on the next cycle and encoded with the loaded state.
- Reset asserted in the BIT1 cycle -> no outValid; inReady 0 during reset and 1 from the first cycle after reset; a following ch0 0x0000 gives outPredictSamp 0x0001.
